pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Generic pipeline stage register with valid/ready handshake, sync flush and optional 2-entry skid.
//  Replaces the per-stage fixed-field flop registers (fetch/decode/execute/memory) with one
//  WIDTH-parametrised stage; callers concatenate their fields into in_data.
//  Adds backpressure, bubble tracking and a flush-drop counter that the fixed stage registers lack.
// PARAMETERS
//  WIDTH  32  payload width in bits (>=1)
//  SKID   1   1: two-entry stage, registered in_ready; 0: single entry, in_ready combinational
//  CNT_W  8   width of saturating drop counter (>=1)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  flush      in   1      sync clear; discards all held entries (hazard/branch squash)
//  in_valid   in   1      upstream offers in_data
//  in_ready   out  1      stage can accept this cycle
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      out_data is valid
//  out_ready  in   1      downstream consumes this cycle
//  out_data   out  WIDTH  head-entry payload, straight from a flop
//  occupancy  out  2      entries held: 0..2 (0..1 when SKID=0)
//  drop_cnt   out  CNT_W  valid entries discarded by flush, saturating
// BEHAVIOUR
//  accept = in_valid & in_ready; emit = out_valid & out_ready; both evaluated each rising clk.
//  Reset (async assert, takes effect without clk): state EMPTY, out_valid=0, out_data=0, skid=0,
//   occupancy=0, drop_cnt=0; in_ready=1 once reset is low (SKID=1 and SKID=0).
//  Latency: accepted data appears on out_data/out_valid the cycle after accept (1 cycle).
//  SKID=1 FSM (state = {skid_v, main_v}):
//   EMPTY: accept -> ONE (main<=in_data).
//   ONE:   accept&emit -> ONE (main<=in_data); accept&~emit -> TWO (skid<=in_data);
//          emit&~accept -> EMPTY; neither -> ONE, main held.
//   TWO:   in_ready=0; emit -> ONE (main<=skid); else hold. Order preserved: main before skid.
//   in_ready = ~skid_v & ~flush (depends only on flops and flush, never on out_ready).
//  SKID=0: single main entry; in_ready = (~out_valid | out_ready) & ~flush; accept&emit
//   in same cycle replaces main, out_valid stays 1 (full-throughput pass-through).
//  flush=1: highest priority after reset. Next state EMPTY, out_valid=0, data regs <= 0;
//   in_ready forced 0 that cycle (no accept); an emit in the flush cycle still completes
//   downstream (entry counted as consumed, not dropped).
//   drop_cnt += (entries held at flush) - (emit?1:0); saturates at 2^CNT_W-1, never wraps.
//  out_data holds its value while out_valid=1 & out_ready=0 (stable under stall).
//  out_data when out_valid=0: last written value or 0 after reset/flush; don't-care to consumers.
//  occupancy = main_v + skid_v, registered, consistent with out_valid (occupancy!=0 <=> out_valid).
//  No combinational path in_valid->out_*; SKID=1 has no path out_ready->in_ready.
//  Reset asserted mid-transfer: all entries lost, drop_cnt cleared (not incremented).
// STRUCTURE
//  Shared header pipe_defs.vh: `define state encodings PS_EMPTY=2'b00, PS_ONE=2'b01,
//   PS_TWO=2'b11, and OCC_W=2; reused by future multi-entry stages.
//  One sub-module: flopenrc #(WIDTH) -- async-reset, sync-clear, active-high-enable register;
//   instantiated for main and (generate, SKID=1) skid payload.
//  FSM, ready logic and drop counter live in this module; SKID selected by generate.
// TESTING
//  1 Reset: hold reset 3 cycles, in_valid=1 -> out_valid=0, occupancy=0, drop_cnt=0, in_ready=1 after release.
//  2 Streaming SKID=1: push 0x00000001..0x00000008 back-to-back, out_ready=1 -> same order, 1-cycle
//    latency, one word per cycle, occupancy stays 1.
//  3 Backpressure: out_ready=0, push 0xA5A5A5A5,0x5A5A5A5A -> occupancy=2, in_ready=0, out_data
//    stable 0xA5A5A5A5; release -> 0xA5A5A5A5 then 0x5A5A5A5A, no loss or duplicate.
//  4 Flush with 2 held, out_ready=0 -> next cycle out_valid=0, occupancy=0, drop_cnt=2;
//    repeat with out_ready=1 -> drop_cnt +1 only.
//  5 Saturation CNT_W=2: four 2-entry flushes -> drop_cnt = 3, stays 3.
//  6 SKID=0: out_ready=0 with main full -> in_ready=0; out_ready=1 & in_valid=1 -> replace, out_valid stays 1.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for valid/ready pipeline stages: entry-state encoding and occupancy width.
package pipe_stage_skid_pkg;

  localparam int OCC_W = 2;

  // Encoding is {skid_v, main_v} so bit 0 doubles as out_valid
  typedef enum logic [1:0] {
    PS_EMPTY = 2'b00,
    PS_ONE   = 2'b01,
    PS_TWO   = 2'b11
  } ps_state_e;

endpackage

// File: rtl/pipe_stage_skid_flopenrc.sv
// Payload register: async reset, synchronous clear (wins over enable), active-high enable.
module flopenrc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      q <= '0;
    else if (clear) q <= '0;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with optional 2-entry skid, sync flush and a
// saturating count of valid entries discarded by flush.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;

  ps_state_e        state;
  logic             main_v, skid_v;
  logic             accept, emit;
  logic             main_en;
  logic [WIDTH-1:0] main_d;
  logic [OCC_W-1:0] occ_q;
  logic [CNT_W-1:0] drop_q;
  logic [OCC_W-1:0] dropped;
  logic [SUM_W-1:0] drop_sum;
  logic [CNT_W-1:0] drop_nxt;

  assign main_v = (state != PS_EMPTY);
  assign skid_v = (state == PS_TWO);
  assign accept = in_valid & in_ready;
  assign emit   = main_v & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic             skid_en;
      logic [WIDTH-1:0] skid_q;

      // in_ready comes from flops only, breaking the out_ready -> in_ready path
      assign in_ready = ~skid_v & ~flush;
      assign main_en  = (accept & (~main_v | emit)) | (skid_v & emit);
      assign main_d   = skid_v ? skid_q : in_data;
      assign skid_en  = accept & main_v & ~emit;

      flopenrc #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .clear (flush),
        .d     (in_data),
        .q     (skid_q)
      );
    end else begin : g_noskid
      assign in_ready = (~main_v | out_ready) & ~flush;
      assign main_en  = accept;
      assign main_d   = in_data;
    end
  endgenerate

  flopenrc #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .clear (flush),
    .d     (main_d),
    .q     (out_data)
  );

  // An entry emitted in the flush cycle was consumed downstream, so it is not a drop
  assign dropped  = occ_q - OCC_W'(emit);
  assign drop_sum = SUM_W'(drop_q) + SUM_W'(dropped);
  assign drop_nxt = (drop_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= PS_EMPTY;
      occ_q  <= '0;
      drop_q <= '0;
    end else if (flush) begin
      state  <= PS_EMPTY;
      occ_q  <= '0;
      drop_q <= drop_nxt;
    end else begin
      occ_q <= occ_q + OCC_W'(accept) - OCC_W'(emit);
      unique case (state)
        PS_EMPTY: if (accept) state <= PS_ONE;
        PS_ONE: begin
          if (accept & ~emit & (SKID != 0)) state <= PS_TWO;
          else if (emit & ~accept)          state <= PS_EMPTY;
        end
        PS_TWO:   if (emit) state <= PS_ONE;
        default:  state <= PS_EMPTY;
      endcase
    end
  end

  assign out_valid = main_v;
  assign occupancy = occ_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench: three stages (skid/CNT_W=8, skid/CNT_W=2, no-skid) driven by phased
// random traffic and compared against a queue model of the stage contents.
module tb_pipe_stage_skid;

  logic clk;
  logic reset;
  int   p_valid, p_ready, p_flush;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input bit ok, input int inst, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL inst%0d %s: got %0h expected %0h at %0t", inst, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SK = (g == 2) ? 0 : 1;
    localparam int CW = (g == 1) ? 2 : 8;

    logic          flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0]   in_data, out_data, r;
    logic [1:0]    occupancy;
    logic [CW-1:0] drop_cnt;
    logic [31:0]   q[$];
    int            seq;
    int            dm;

    pipe_stage_skid #(.WIDTH(32), .SKID(SK), .CNT_W(CW)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy),
      .drop_cnt  (drop_cnt)
    );

    // Driver: new inputs just after each rising edge; accepted words go to the scoreboard
    initial begin
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0; seq = 1; dm = 0;
      forever begin
        @(posedge clk); #1;
        r         = $urandom;
        in_valid  = (int'($urandom_range(0, 99)) < p_valid);
        out_ready = (int'($urandom_range(0, 99)) < p_ready);
        flush     = (int'($urandom_range(0, 99)) < p_flush);
        in_data   = {seq[15:0], r[15:0]};
        @(negedge clk); #1;
        if (!reset && in_valid && in_ready && !flush) begin
          q.push_back(in_data);
          seq++;
        end
      end
    end

    // Monitor: compares the stage against the model, then advances the model for the next edge
    always @(negedge clk) begin
      int n;
      bit exp_ir, em;
      if (reset) begin
        chk(out_valid == 1'b0, g, "reset out_valid", out_valid, 0);
        chk(occupancy == 2'd0, g, "reset occupancy", occupancy, 0);
        chk(drop_cnt == '0,    g, "reset drop_cnt",  drop_cnt, 0);
        q.delete();
        dm = 0;
      end else begin
        n = q.size();
        exp_ir = ((SK != 0) ? (n < 2) : (n == 0 || out_ready)) && !flush;
        chk(int'(occupancy) == n, g, "occupancy", occupancy, n);
        chk(out_valid == (n != 0), g, "out_valid", out_valid, (n != 0));
        chk(in_ready == exp_ir,    g, "in_ready",  in_ready, exp_ir);
        chk(int'(drop_cnt) == dm,  g, "drop_cnt",  drop_cnt, dm);
        if (n != 0) chk(out_data == q[0], g, "out_data", out_data, q[0]);
        em = (n != 0) && out_ready;
        if (em) void'(q.pop_front());
        if (flush) begin
          dm = dm + q.size();
          if (dm > (1 << CW) - 1) dm = (1 << CW) - 1;
          q.delete();
        end
      end
    end
  end

  task automatic phase(input int v, input int rd, input int f, input int n);
    p_valid = v; p_ready = rd; p_flush = f;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    reset = 1'b1;
    p_valid = 100; p_ready = 0; p_flush = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    phase(0,   0,   0,   2);   // idle after reset
    phase(100, 100, 0,   12);  // streaming, full throughput
    phase(100, 0,   0,   6);   // backpressure: fill and stall
    phase(0,   100, 0,   4);   // release in order
    phase(100, 0,   0,   4);   // fill, then flush with nothing emitted
    phase(0,   0,   100, 1);
    phase(100, 0,   0,   4);   // fill, then flush while emitting
    phase(0,   100, 100, 1);
    for (int i = 0; i < 4; i++) begin  // repeated full flushes drive counters into saturation
      phase(100, 0,   0,   3);
      phase(0,   0,   100, 1);
    end
    phase(100, 100, 0,   4);   // no-skid stage replaces main while out_valid stays high
    phase(60,  70,  3,   800);
    phase(90,  30,  2,   800);
    phase(40,  95,  4,   800);
    phase(100, 100, 1,   300);
    phase(100, 20,  0,   20);
    // Asynchronous reset in the middle of traffic
    @(negedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    phase(70, 70, 0, 20);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
